// File: rtl/note_detect.sv
// rtl/note_detect.sv - per-lane set-pixel counter over raster frames, reporting a note bitmask per frame
// Define NOTE_DETECT_DEBOUNCE_EN to require two consecutive hit frames before a note rises.
module note_detect #(
  parameter int NUM_LANES  = 5,
  parameter int LANE_X0    = 200,
  parameter int LANE_PITCH = 64,
  parameter int LANE_WIDTH = 32,
  parameter int ROW_TOP    = 600,
  parameter int ROW_BOTTOM = 631,
  parameter int COUNT_W    = 10
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 VDE,
  input  logic                 VSync,
  input  logic                 ProcessIn,
  input  logic [COUNT_W-1:0]   HitMin,
  output logic [NUM_LANES-1:0] Notes,
  output logic                 NotesValid,
  output logic                 InWindow
);

  typedef enum logic {UNSYNCED, ARMED} state_t;
  state_t state_q, state_d;

  logic [10:0]          x_q, y_q;
  logic                 vde_q, vsync_q;
  logic [COUNT_W-1:0]   count_q [NUM_LANES];
  logic [NUM_LANES-1:0] lane_hit, hit, notes_next;
  logic                 frame_end, vde_fall, row_in, accum_en, report;

  assign frame_end = VSync && !vsync_q;
  assign vde_fall  = vde_q && !VDE;
  assign row_in    = (32'(y_q) >= 32'(ROW_TOP)) && (32'(y_q) <= 32'(ROW_BOTTOM));

  always_comb begin
    lane_hit = '0;
    hit      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_hit[i] = row_in
                 && (32'(x_q) >= 32'(LANE_X0 + i * LANE_PITCH))
                 && (32'(x_q) <  32'(LANE_X0 + i * LANE_PITCH + LANE_WIDTH));
      hit[i] = (count_q[i] >= HitMin);
    end
  end

  // The frame that ends while UNSYNCED was only partially observed, so it only arms.
  always_comb begin
    state_d  = state_q;
    accum_en = 1'b0;
    report   = 1'b0;
    case (state_q)
      UNSYNCED: begin
        if (frame_end) state_d = ARMED;
      end
      ARMED: begin
        accum_en = !frame_end;
        report   = frame_end;
      end
      default: state_d = UNSYNCED;
    endcase
  end

`ifdef NOTE_DETECT_DEBOUNCE_EN
  logic [NUM_LANES-1:0] prev_hit_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_hit_q <= '0;
    end else if (report) begin
      prev_hit_q <= hit;
    end
  end

  assign notes_next = hit & prev_hit_q;
`else
  assign notes_next = hit;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= UNSYNCED;
      x_q        <= '0;
      y_q        <= '0;
      vde_q      <= 1'b0;
      vsync_q    <= 1'b0;
      Notes      <= '0;
      NotesValid <= 1'b0;
      InWindow   <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) count_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      vde_q      <= VDE;
      vsync_q    <= VSync;
      NotesValid <= report;
      InWindow   <= VDE && (|lane_hit);
      if (report) Notes <= notes_next;

      if (VDE) begin
        if (x_q != 11'h7ff) x_q <= x_q + 11'd1;
      end else if (vde_fall) begin
        x_q <= '0;
      end

      if (frame_end) begin
        y_q <= '0;
      end else if (vde_fall && (y_q != 11'h7ff)) begin
        y_q <= y_q + 11'd1;
      end

      for (int i = 0; i < NUM_LANES; i++) begin
        if (frame_end) begin
          count_q[i] <= '0;
        end else if (accum_en && VDE && ProcessIn && lane_hit[i] && (count_q[i] != '1)) begin
          count_q[i] <= count_q[i] + COUNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_note_detect.sv
// tb/tb_note_detect.sv - directed and randomized frames for note_detect against a coordinate-level model
module tb_note_detect;

  localparam int NL         = 5;
  localparam int LANE_X0    = 200;
  localparam int LANE_PITCH = 64;
  localparam int LANE_WIDTH = 32;
  localparam int ROW_TOP    = 600;
  localparam int ROW_BOTTOM = 631;
  localparam int CMAX       = 1023;

  logic          CLK = 1'b0;
  logic          RST, VDE, VSync, ProcessIn;
  logic [9:0]    HitMin;
  logic [NL-1:0] Notes;
  logic          NotesValid, InWindow;

  note_detect dut (
    .CLK(CLK), .RST(RST), .VDE(VDE), .VSync(VSync), .ProcessIn(ProcessIn),
    .HitMin(HitMin), .Notes(Notes), .NotesValid(NotesValid), .InWindow(InWindow)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model state: raster coordinates of the driven pixel come straight from the stimulus loops.
  int            px, py, cur_row;
  int            mcount [NL];
  bit            marmed, last_vs;
  logic [NL-1:0] mnotes, mprev;

  function automatic bit in_lane(int i, int x, int y);
    int lo;
    lo = LANE_X0 + i * LANE_PITCH;
    return (y >= ROW_TOP) && (y <= ROW_BOTTOM) && (x >= lo) && (x < lo + LANE_WIDTH);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic          exp_nv, exp_win;
    logic [NL-1:0] hits;
    bit            fe;
    exp_nv  = 1'b0;
    exp_win = 1'b0;
    hits    = '0;
    fe      = VSync && !last_vs;
    if (RST) begin
      marmed  = 0;
      mnotes  = '0;
      mprev   = '0;
      last_vs = 0;
      for (int i = 0; i < NL; i++) mcount[i] = 0;
    end else begin
      for (int i = 0; i < NL; i++) if (VDE && in_lane(i, px, py)) exp_win = 1'b1;
      if (fe) begin
        if (marmed) begin
          for (int i = 0; i < NL; i++) hits[i] = (mcount[i] >= int'(HitMin));
`ifdef NOTE_DETECT_DEBOUNCE_EN
          mnotes = hits & mprev;
`else
          mnotes = hits;
`endif
          mprev  = hits;
          exp_nv = 1'b1;
        end
        marmed = 1;
        for (int i = 0; i < NL; i++) mcount[i] = 0;
      end else if (marmed && VDE && ProcessIn) begin
        for (int i = 0; i < NL; i++)
          if (in_lane(i, px, py) && mcount[i] < CMAX) mcount[i]++;
      end
      last_vs = VSync;
    end
    @(posedge CLK);
    #1;
    chk("in_window", 32'(InWindow), 32'(exp_win));
    chk("notes_valid", 32'(NotesValid), 32'(exp_nv));
    chk("notes", 32'(Notes), 32'(mnotes));
  endtask

  task automatic idle(int n);
    VDE = 0; ProcessIn = 0; VSync = 0;
    repeat (n) step();
  endtask

  task automatic drive_row(int len, int lo, int hi, bit rnd);
    for (int c = 0; c < len; c++) begin
      VDE = 1; px = c; py = cur_row;
      ProcessIn = ((c >= lo) && (c <= hi)) || (rnd && ($urandom_range(0, 2) == 0));
      step();
    end
    VDE = 0;
    ProcessIn = rnd && ($urandom_range(0, 1) == 1);
    step();
    ProcessIn = 0;
    cur_row++;
  endtask

  task automatic skip_to(int r);
    while (cur_row < r) drive_row(1, -1, -1, 0);
  endtask

  task automatic vsync_pulse();
    VDE = 0; ProcessIn = 0;
    VSync = 1; step(); step();
    VSync = 0; step();
    cur_row = 0;
  endtask

  initial begin
    RST = 1; VDE = 0; VSync = 0; ProcessIn = 0; HitMin = 10'd1;
    px = 0; py = 0; cur_row = 0;
    marmed = 0; last_vs = 0; mnotes = '0; mprev = '0;
    for (int i = 0; i < NL; i++) mcount[i] = 0;
    step(); step();
    RST = 0;
    idle(4);

    // First VSync only arms; second reports an empty frame.
    vsync_pulse(); idle(3); vsync_pulse(); idle(2);

    // Every pixel set: 1024 per lane must saturate at 1023, not wrap.
    HitMin = 10'd1023;
    skip_to(ROW_TOP);
    repeat (32) drive_row(490, 0, 489, 0);
    vsync_pulse();

    // 40 pixels in lane 2 plus 40 just below the window rows.
    HitMin = 10'd40;
    skip_to(ROW_TOP);
    drive_row(360, 328, 359, 0);
    drive_row(336, 328, 335, 0);
    skip_to(ROW_BOTTOM + 1);
    drive_row(240, 200, 239, 0);
    vsync_pulse();

    // Right edge of lane 0: last column inside, first column outside.
    HitMin = 10'd1;
    skip_to(ROW_TOP);
    drive_row(LANE_X0 + LANE_WIDTH + 1, LANE_X0 + LANE_WIDTH - 1, LANE_X0 + LANE_WIDTH, 0);
    vsync_pulse();

    // Random frames.
    repeat (2) begin
      HitMin = 10'($urandom_range(0, 300));
      skip_to(ROW_TOP);
      repeat (32) drive_row(int'($urandom_range(1, 490)), -1, -1, 1);
      vsync_pulse();
    end

    // HitMin of zero on an empty frame: every lane hits.
    HitMin = 10'd0;
    idle(3); vsync_pulse();

    // Lane 3 hit, hit, miss.
    HitMin = 10'd1;
    for (int f = 0; f < 3; f++) begin
      skip_to(ROW_TOP);
      if (f < 2) drive_row(424, 392, 423, 0);
      else drive_row(424, -1, -1, 0);
      vsync_pulse();
    end

    // Reset after 100 lane-1 hits: partial frame never reported.
    skip_to(ROW_TOP);
    repeat (4) drive_row(296, 264, 288, 0);
    RST = 1; step();
    RST = 0;
    idle(2);
    vsync_pulse();
    HitMin = 10'd5;
    skip_to(ROW_TOP);
    drive_row(466, 456, 465, 0);
    vsync_pulse();

    // Frame end arriving with VDE high: that pixel must not count.
    HitMin = 10'd6;
    skip_to(ROW_TOP);
    for (int c = 0; c < 205; c++) begin
      VDE = 1; px = c; py = cur_row; ProcessIn = (c >= LANE_X0);
      step();
    end
    px = 205; ProcessIn = 1; VSync = 1;
    step();
    VDE = 0; ProcessIn = 0;
    step();
    VSync = 0;
    step();
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
